multicycle_ctrl: RTL and testbench

Multi-cycle control sequencer for the RV64 integer core. It steps each instruction through fetch, decode, execute, memory and writeback. It drives the shared memory port through a req/ready handshake, and it drives the datapath enables, including the immediate-format select consumed by the immediate generator. It sits beside the datapath, owns no data registers, and raises a sticky fault on an illegal opcode or a memory timeout.

---
 rtl/ctrl_pkg.sv | 36 +++
 rtl/ctrl_decode.sv | 26 ++
 rtl/multicycle_ctrl.sv | 162 ++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multicycle control sequencer.
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [2:0] F3_BEQ    = 3'b000;

  typedef enum logic [1:0] {IMM_I, IMM_S, IMM_B, IMM_NONE} imm_sel_t;
  typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_FUNCT, ALU_ADDW} alu_op_t;
  typedef enum logic [2:0] {
    CLS_LD, CLS_SD, CLS_BEQ, CLS_R, CLS_ADDI, CLS_ADDIW, CLS_ILLEGAL
  } instr_class_t;

  function automatic imm_sel_t class_imm(input instr_class_t cls);
    case (cls)
      CLS_SD:  return IMM_S;
      CLS_BEQ: return IMM_B;
      CLS_R:   return IMM_NONE;
      default: return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode classifier; the sequencer registers its result in DECODE.
module ctrl_decode import ctrl_pkg::*; (
  input  logic [31:0]  instr,
  output instr_class_t instr_class
);

  logic instr_unused_s;
  assign instr_unused_s = ^{instr[31:15], instr[11:7]};

  always_comb begin
    instr_class = CLS_ILLEGAL;
    case (instr[6:0])
      OP_LOAD:   instr_class = CLS_LD;
      OP_STORE:  instr_class = CLS_SD;
      OP_BRANCH: begin
        if (instr[14:12] == F3_BEQ) instr_class = CLS_BEQ;
        else                        instr_class = CLS_ILLEGAL;
      end
      OP_REG:    instr_class = CLS_R;
      OP_IMM:    instr_class = CLS_ADDI;
      OP_IMM32:  instr_class = CLS_ADDIW;
      default:   instr_class = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control sequencer: FETCH/DECODE/EXEC/MEM/WB with memory
// handshake, wait timeout and a sticky fault that parks the core in HALT.
module multicycle_ctrl import ctrl_pkg::*; #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_is_fetch,
  output logic        ir_we,
  output logic        pc_we,
  output logic        pc_src,
  output logic [1:0]  imm_sel,
  output logic [1:0]  alu_op,
  output logic        alu_src_b,
  output logic        reg_we,
  output logic        mem_to_reg,
  output logic        fault,
  output logic [2:0]  state
);

  localparam int unsigned   CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t             state_q, state_d;
  instr_class_t       cls_q, cls_d, dec_cls_s;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               fault_q, fault_d;
  logic               done_s, wait_s, expire_s;

  ctrl_decode u_decode (
    .instr       (instr),
    .instr_class (dec_cls_s)
  );

  assign done_s   = mem_req & mem_ready;
  assign wait_s   = mem_req & ~mem_ready;
  assign expire_s = wait_s && (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    fault_d = fault_q;
    case (state_q)
      ST_FETCH: begin
        if (done_s) begin
          state_d = ST_DECODE;
        end else if (expire_s) begin
          state_d = ST_HALT;
          fault_d = 1'b1;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_DECODE: begin
        cls_d = dec_cls_s;
        if (dec_cls_s == CLS_ILLEGAL) begin
          state_d = ST_HALT;
          fault_d = 1'b1;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        case (cls_q)
          CLS_LD, CLS_SD: state_d = ST_MEM;
          CLS_BEQ:        state_d = ST_FETCH;
          default:        state_d = ST_WB;
        endcase
      end
      ST_MEM: begin
        if (done_s) begin
          state_d = (cls_q == CLS_SD) ? ST_FETCH : ST_WB;
        end else if (expire_s) begin
          state_d = ST_HALT;
          fault_d = 1'b1;
        end else begin
          state_d = ST_MEM;
        end
      end
      ST_WB:   state_d = ST_FETCH;
      ST_HALT: state_d = ST_HALT;
      default: begin
        state_d = ST_HALT;
        fault_d = 1'b1;
      end
    endcase
    // Wait counter only survives uninterrupted stalls within one state.
    if ((state_d != state_q) || !wait_s) cnt_d = '0;
    else                                 cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_FETCH;
      cls_q   <= CLS_ILLEGAL;
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end

  assign state = state_q;
  assign fault = fault_q;

  // While reset is held the decode behaves as HALT so no enable leaks out.
  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_is_fetch = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_src       = 1'b0;
    imm_sel      = IMM_I;
    alu_op       = ALU_ADD;
    alu_src_b    = 1'b0;
    reg_we       = 1'b0;
    mem_to_reg   = 1'b0;
    case (reset_n ? state_q : ST_HALT)
      ST_FETCH: begin
        mem_req      = 1'b1;
        mem_is_fetch = 1'b1;
        ir_we        = mem_ready;
        pc_we        = mem_ready;
      end
      ST_EXEC: begin
        imm_sel   = class_imm(cls_q);
        alu_src_b = (cls_q != CLS_BEQ) && (cls_q != CLS_R);
        case (cls_q)
          CLS_R:     alu_op = ALU_FUNCT;
          CLS_ADDIW: alu_op = ALU_ADDW;
          CLS_BEQ: begin
            alu_op = ALU_SUB;
            pc_we  = zero;
            pc_src = 1'b1;
          end
          default:   alu_op = ALU_ADD;
        endcase
      end
      ST_MEM: begin
        mem_req = 1'b1;
        mem_we  = (cls_q == CLS_SD);
      end
      ST_WB: begin
        reg_we     = 1'b1;
        mem_to_reg = (cls_q == CLS_LD);
      end
      default: begin
        mem_req = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed and randomized bench for multicycle_ctrl against a per-instruction
// behavioural model of the expected cycle trace.
module tb_multicycle_ctrl;
  import ctrl_pkg::*;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        reset_n, zero, mem_ready;
  logic [31:0] instr;
  logic        mem_req, mem_we, mem_is_fetch, ir_we, pc_we, pc_src;
  logic [1:0]  imm_sel, alu_op;
  logic        alu_src_b, reg_we, mem_to_reg, fault;
  logic [2:0]  state;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [2:0] st;
    logic       req, we, isf, irwe, pcwe, pcsrc;
    logic [1:0] imm, alu;
    logic       srcb, regwe, m2r, flt;
  } vec_t;

  typedef enum int {K_LD, K_SD, K_BEQ, K_R, K_ADDI, K_ADDIW, K_BAD} kind_e;

  vec_t obs;
  assign obs = {state, mem_req, mem_we, mem_is_fetch, ir_we, pc_we, pc_src,
                imm_sel, alu_op, alu_src_b, reg_we, mem_to_reg, fault};

  multicycle_ctrl #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset_n(reset_n), .instr(instr), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
    .mem_is_fetch(mem_is_fetch), .ir_we(ir_we), .pc_we(pc_we),
    .pc_src(pc_src), .imm_sel(imm_sel), .alu_op(alu_op),
    .alu_src_b(alu_src_b), .reg_we(reg_we), .mem_to_reg(mem_to_reg),
    .fault(fault), .state(state)
  );

  always #5 clk = ~clk;

  function automatic kind_e kind_of(input logic [31:0] w);
    case (w[6:0])
      7'h03:   return K_LD;
      7'h23:   return K_SD;
      7'h63:   return (w[14:12] == 3'b000) ? K_BEQ : K_BAD;
      7'h33:   return K_R;
      7'h13:   return K_ADDI;
      7'h1B:   return K_ADDIW;
      default: return K_BAD;
    endcase
  endfunction

  function automatic vec_t only_state(input logic [2:0] st, input logic flt);
    vec_t e;
    e     = '0;
    e.st  = st;
    e.flt = flt;
    return e;
  endfunction

  task automatic chk(input string tag, input vec_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: drive ready, check settled outputs, move to next negedge.
  task automatic cyc(input string tag, input logic rdy, input vec_t exp);
    mem_ready = rdy;
    #1;
    chk(tag, exp);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    mem_ready = 1'($urandom_range(0, 1));
    #1;
    chk("reset", only_state(ST_FETCH, 1'b0));
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic halted(input int n);
    for (int i = 0; i < n; i++)
      cyc("halt", 1'($urandom_range(0, 1)), only_state(ST_HALT, 1'b1));
    do_reset();
  endtask

  // Up to T request cycles; ready arrives after 'waits' stalls or the access times out.
  task automatic mem_phase(input string tag, input logic [2:0] st, input int waits,
                           input logic we, input logic isf, output logic ok);
    vec_t e;
    e     = only_state(st, 1'b0);
    e.req = 1'b1;
    e.we  = we;
    e.isf = isf;
    for (int k = 0; k < T; k++) begin
      if (k == waits) begin
        e.irwe = isf;
        e.pcwe = isf;
        cyc(tag, 1'b1, e);
        ok = 1'b1;
        return;
      end
      cyc(tag, 1'b0, e);
    end
    ok = 1'b0;
  endtask

  task automatic exec_vec(input kind_e k, input logic z, output vec_t e);
    e = only_state(ST_EXEC, 1'b0);
    case (k)
      K_SD:    begin e.imm = IMM_S;    e.alu = ALU_ADD;   end
      K_BEQ:   begin e.imm = IMM_B;    e.alu = ALU_SUB;   end
      K_R:     begin e.imm = IMM_NONE; e.alu = ALU_FUNCT; end
      K_ADDIW: begin e.imm = IMM_I;    e.alu = ALU_ADDW;  end
      default: begin e.imm = IMM_I;    e.alu = ALU_ADD;   end
    endcase
    e.srcb  = !(k == K_BEQ || k == K_R);
    e.pcwe  = (k == K_BEQ) ? z : 1'b0;
    e.pcsrc = (k == K_BEQ);
  endtask

  task automatic run_instr(input logic [31:0] w, input logic z, input int fw, input int dw);
    kind_e k;
    logic  ok;
    vec_t  e;
    k     = kind_of(w);
    instr = w;
    zero  = z;
    mem_phase("fetch", ST_FETCH, fw, 1'b0, 1'b1, ok);
    if (!ok) begin halted(3); return; end
    cyc("decode", 1'($urandom_range(0, 1)), only_state(ST_DECODE, 1'b0));
    if (k == K_BAD) begin halted(20); return; end
    exec_vec(k, z, e);
    cyc("exec", 1'($urandom_range(0, 1)), e);
    if (k == K_LD || k == K_SD) begin
      mem_phase("mem", ST_MEM, dw, (k == K_SD), 1'b0, ok);
      if (!ok) begin halted(3); return; end
    end
    if (k != K_SD && k != K_BEQ) begin
      e       = only_state(ST_WB, 1'b0);
      e.regwe = 1'b1;
      e.m2r   = (k == K_LD);
      cyc("wb", 1'($urandom_range(0, 1)), e);
    end
  endtask

  initial begin
    logic [31:0] w;
    logic        ok;
    vec_t        e;
    int          sel, fw, dw;

    reset_n   = 1'b0;
    mem_ready = 1'b0;
    zero      = 1'b0;
    instr     = 32'h0000_0000;
    do_reset();

    run_instr(32'h0050_0093, 1'b0, 0, 0);   // ADDI
    run_instr(32'h0000_B103, 1'b0, 2, 0);   // LD, 2 fetch waits
    run_instr(32'h0020_B023, 1'b0, 0, 0);   // SD
    run_instr(32'h0020_8463, 1'b1, 0, 0);   // BEQ taken
    run_instr(32'h0020_8463, 1'b0, 0, 0);   // BEQ not taken
    run_instr(32'h0000_007F, 1'b0, 0, 0);   // illegal opcode
    run_instr(32'h0050_0093, 1'b0, T, 0);   // fetch timeout
    run_instr(32'h0050_0093, 1'b0, T - 1, 0); // ready on terminal cycle
    run_instr(32'h0020_B023, 1'b0, 0, T);   // data timeout
    run_instr(32'h0000_B103, 1'b1, 1, T - 1);

    // Reset dropped mid-MEM of a store must kill mem_we at once.
    instr = 32'h0020_B023;
    zero  = 1'b0;
    mem_phase("fetch", ST_FETCH, 0, 1'b0, 1'b1, ok);
    cyc("decode", 1'b0, only_state(ST_DECODE, 1'b0));
    exec_vec(K_SD, 1'b0, e);
    cyc("exec", 1'b0, e);
    mem_ready = 1'b0;
    #1;
    e     = only_state(ST_MEM, 1'b0);
    e.req = 1'b1;
    e.we  = 1'b1;
    chk("sd_mem", e);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_in_mem", only_state(ST_FETCH, 1'b0));
    @(negedge clk);
    mem_ready = 1'b1;
    #1;
    chk("rst_next", only_state(ST_FETCH, 1'b0));
    @(negedge clk);
    reset_n = 1'b1;

    for (int n = 0; n < 80; n++) begin
      w   = $urandom;
      sel = $urandom_range(0, 12);
      case (sel)
        0, 1:    w[6:0] = 7'h03;
        2, 3:    w[6:0] = 7'h23;
        4, 5:    begin w[6:0] = 7'h63; w[14:12] = 3'b000; end
        6, 7:    w[6:0] = 7'h33;
        8, 11:   w[6:0] = 7'h13;
        9:       w[6:0] = 7'h1B;
        10:      w[6:0] = 7'h63;
        default: w[6:0] = 7'($urandom);
      endcase
      fw = ($urandom_range(0, 15) == 0) ? T : $urandom_range(0, T - 1);
      dw = ($urandom_range(0, 15) == 0) ? T : $urandom_range(0, T - 1);
      run_instr(w, 1'($urandom_range(0, 1)), fw, dw);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
